// File: rtl/pipe_stage_skid_pkg.sv
// pipe_pkg: shared types and defaults for the elastic EX/MEM pipeline stage.
//   - width defaults used as parameter defaults by the stage, its interface
//     and its entry register
//   - CTRL_NOP: the control value a bubble carries (no memory or RF write)
//   - ex_mem_t: EX/MEM payload record at the default widths
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int PC_W_DEF   = 16;
  localparam int CTRL_W_DEF = 2;
  localparam int CNT_W_DEF  = 8;

  // Control bit positions at the EX/MEM boundary.
  localparam int CTRL_BIT_MEM_WRITE  = 0;
  localparam int CTRL_BIT_MEM_TO_REG = 1;

  localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = '0;

  typedef struct packed {
    logic [CTRL_W_DEF-1:0] ctrl;
    logic [PC_W_DEF-1:0]   pc;
    logic [DATA_W_DEF-1:0] rd2;
    logic [DATA_W_DEF-1:0] alu;
  } ex_mem_t;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if: valid/ready handshake plus EX/MEM payload.
//   master: drives valid, ctrl, pc, rd2, alu; receives ready
//   slave : receives valid, ctrl, pc, rd2, alu; drives ready
interface pipe_stage_skid_if
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int PC_W   = PC_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] rd2;
  logic [DATA_W-1:0] alu;

  modport master (output valid, ctrl, pc, rd2, alu, input  ready);
  modport slave  (input  valid, ctrl, pc, rd2, alu, output ready);

endinterface

// File: rtl/pipe_stage_skid_entry_reg.sv
// pipe_entry_reg: one valid flag plus control and payload register.
//   clk, rst     : clock, asynchronous active-high reset (clears everything)
//   load         : capture d_ctrl/d_pay and set valid
//   clear        : drop valid and zero control (wins over load)
//   d_ctrl/d_pay : incoming control and packed payload
//   valid        : entry holds an instruction
//   q_ctrl/q_pay : held control and payload
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int PAY_W  = PC_W_DEF + 2 * DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [PAY_W-1:0]  d_pay,
  output logic              valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [PAY_W-1:0]  q_pay
);

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid  <= 1'b0;
      q_ctrl <= '0;
      q_pay  <= '0;
    end else if (clear) begin
      // Payload keeps stale data; only control must read as a bubble.
      valid  <= 1'b0;
      q_ctrl <= CTRL_W'(CTRL_NOP);
    end else if (load) begin
      valid  <= 1'b1;
      q_ctrl <= d_ctrl;
      q_pay  <= d_pay;
    end
  end

endmodule

// File: rtl/pipe_stage.sv
// pipe_stage_skid: elastic pipeline stage register (EX/MEM and similar).
//   clk, rst  : clock, asynchronous active-high reset
//   flush     : synchronous squash of every held entry and the current input
//   in_if     : upstream handshake (slave): valid/ctrl/pc/rd2/alu in, ready out
//   out_if    : downstream handshake (master): valid/ctrl/pc/rd2/alu out, ready in
//   stall_cnt : saturating count of cycles with out valid but not accepted
// SKID_EN=1 gives a main + skid pair with in_ready taken straight from the
// skid flag (no path from out_ready); SKID_EN=0 is a single entry whose
// in_ready is combinational on out_ready.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PC_W    = PC_W_DEF,
  parameter int CTRL_W  = CTRL_W_DEF,
  parameter int SKID_EN = 1,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  pipe_stage_skid_if.slave    in_if,
  pipe_stage_skid_if.master   out_if,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam int PAY_W = PC_W + 2 * DATA_W;

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [PAY_W-1:0]  main_pay;
  logic              main_load;
  logic              main_clear;
  logic [CTRL_W-1:0] main_d_ctrl;
  logic [PAY_W-1:0]  main_d_pay;

  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [PAY_W-1:0]  skid_pay;

  logic [PAY_W-1:0]  in_pay;
  logic              accept;
  logic              retire;

  assign in_pay = {in_if.pc, in_if.rd2, in_if.alu};
  assign accept = in_if.valid && in_if.ready;
  assign retire = main_valid && out_if.ready;

  // While the skid holds data, upstream is stalled, so main can only ever be
  // refilled from the skid; otherwise it refills from the input.
  assign main_d_ctrl = skid_valid ? skid_ctrl : in_if.ctrl;
  assign main_d_pay  = skid_valid ? skid_pay  : in_pay;

  generate
    if (SKID_EN != 0) begin : g_skid
      logic skid_load;
      logic skid_clear;

      // NOTE: every always_comb output gets a default first so no path
      // leaves it unassigned and infers a latch.
      always_comb begin
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (flush) begin
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end else if (skid_valid) begin
          // in_ready is low here, so the only possible move is skid -> main.
          if (retire) begin
            main_load  = 1'b1;
            skid_clear = 1'b1;
          end
        end else if (accept) begin
          if (main_valid && !retire) skid_load = 1'b1;
          else                       main_load = 1'b1;
        end else if (retire) begin
          main_clear = 1'b1;
        end
      end

      assign in_if.ready = !skid_valid;

      pipe_entry_reg #(.CTRL_W(CTRL_W), .PAY_W(PAY_W)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (skid_load),
        .clear  (skid_clear),
        .d_ctrl (in_if.ctrl),
        .d_pay  (in_pay),
        .valid  (skid_valid),
        .q_ctrl (skid_ctrl),
        .q_pay  (skid_pay)
      );
    end else begin : g_single
      always_comb begin
        main_load  = 1'b0;
        main_clear = 1'b0;
        if (flush)       main_clear = 1'b1;
        else if (accept) main_load  = 1'b1;
        else if (retire) main_clear = 1'b1;
      end

      assign in_if.ready = !main_valid || out_if.ready;
      assign skid_valid  = 1'b0;
      assign skid_ctrl   = '0;
      assign skid_pay    = '0;
    end
  endgenerate

  pipe_entry_reg #(.CTRL_W(CTRL_W), .PAY_W(PAY_W)) u_main (
    .clk    (clk),
    .rst    (rst),
    .load   (main_load),
    .clear  (main_clear),
    .d_ctrl (main_d_ctrl),
    .d_pay  (main_d_pay),
    .valid  (main_valid),
    .q_ctrl (main_ctrl),
    .q_pay  (main_pay)
  );

  assign out_if.valid                        = main_valid;
  assign out_if.ctrl                         = main_ctrl;
  assign {out_if.pc, out_if.rd2, out_if.alu} = main_pay;

  // Counts backpressure only; flush deliberately leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_if.ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: dut_a (skid, 4-bit counter) and dut_b (single
// entry, 8-bit counter) share one stimulus. A queue model per instance gives
// the expected outputs each cycle; directed checks pin literal values.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [1:0]  in_ctrl;
  logic [15:0] in_pc;
  logic [31:0] in_rd2;
  logic [31:0] in_alu;
  logic        out_ready;
  logic [3:0]  stall_a;
  logic [7:0]  stall_b;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_stage_skid_if ia ();
  pipe_stage_skid_if oa ();
  pipe_stage_skid_if ib ();
  pipe_stage_skid_if ob ();

  assign ia.valid = in_valid;
  assign ia.ctrl  = in_ctrl;
  assign ia.pc    = in_pc;
  assign ia.rd2   = in_rd2;
  assign ia.alu   = in_alu;
  assign ib.valid = in_valid;
  assign ib.ctrl  = in_ctrl;
  assign ib.pc    = in_pc;
  assign ib.rd2   = in_rd2;
  assign ib.alu   = in_alu;
  assign oa.ready = out_ready;
  assign ob.ready = out_ready;

  pipe_stage_skid #(.SKID_EN(1), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_if(ia), .out_if(oa), .stall_cnt(stall_a)
  );

  pipe_stage_skid #(.SKID_EN(0), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_if(ib), .out_if(ob), .stall_cnt(stall_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a FIFO of held instructions. Skid stage holds up to two and is
  // ready while it holds fewer than two; single stage holds one and is
  // ready when empty or when the head is leaving this cycle.
  ex_mem_t qa[$];
  ex_mem_t qb[$];
  int      sa = 0;
  int      sb = 0;

  always @(posedge clk or posedge rst) begin
    ex_mem_t e;
    bit acc_a, ret_a, acc_b, ret_b;
    if (rst) begin
      qa.delete();
      qb.delete();
      sa = 0;
      sb = 0;
    end else begin
      e.ctrl = in_ctrl; e.pc = in_pc; e.rd2 = in_rd2; e.alu = in_alu;
      acc_a = in_valid && (qa.size() < 2);
      ret_a = (qa.size() != 0) && out_ready;
      acc_b = in_valid && ((qb.size() == 0) || out_ready);
      ret_b = (qb.size() != 0) && out_ready;
      if ((qa.size() != 0) && !out_ready && sa < 15)  sa++;
      if ((qb.size() != 0) && !out_ready && sb < 255) sb++;
      if (flush) begin
        qa.delete();
        qb.delete();
      end else begin
        if (ret_a) void'(qa.pop_front());
        if (acc_a) qa.push_back(e);
        if (ret_b) void'(qb.pop_front());
        if (acc_b) qb.push_back(e);
      end
    end
  end

  // Per-cycle comparison, on the falling edge, before stimulus changes.
  always @(negedge clk) begin
    check("a_in_ready", 64'(ia.ready), 64'(qa.size() < 2));
    check("a_out_valid", 64'(oa.valid), 64'(qa.size() != 0));
    if (qa.size() != 0) begin
      check("a_out_ctrl", 64'(oa.ctrl), 64'(qa[0].ctrl));
      check("a_out_pc",   64'(oa.pc),   64'(qa[0].pc));
      check("a_out_rd2",  64'(oa.rd2),  64'(qa[0].rd2));
      check("a_out_alu",  64'(oa.alu),  64'(qa[0].alu));
    end else begin
      check("a_bubble_ctrl", 64'(oa.ctrl), 64'd0);
    end
    check("a_stall_cnt", 64'(stall_a), 64'(sa));

    check("b_in_ready", 64'(ib.ready), 64'((qb.size() == 0) || out_ready));
    check("b_out_valid", 64'(ob.valid), 64'(qb.size() != 0));
    if (qb.size() != 0) begin
      check("b_out_ctrl", 64'(ob.ctrl), 64'(qb[0].ctrl));
      check("b_out_pc",   64'(ob.pc),   64'(qb[0].pc));
      check("b_out_rd2",  64'(ob.rd2),  64'(qb[0].rd2));
      check("b_out_alu",  64'(ob.alu),  64'(qb[0].alu));
    end else begin
      check("b_bubble_ctrl", 64'(ob.ctrl), 64'd0);
    end
    check("b_stall_cnt", 64'(stall_b), 64'(sb));
  end

  // Advance one clock; returns just after the falling edge compare.
  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [1:0] c, input logic [31:0] alu);
    in_valid = v;
    in_ctrl  = c;
    in_pc    = alu[15:0] + 16'h100;
    in_rd2   = ~alu;
    in_alu   = alu;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 2'b00, 32'h0);
    #2;
    check("rst_a_in_ready", 64'(ia.ready), 64'd1);
    check("rst_a_out_valid", 64'(oa.valid), 64'd0);
    check("rst_b_in_ready", 64'(ib.ready), 64'd1);
    step(); step();
    rst = 1'b0;

    // Streaming: each value appears one cycle after acceptance.
    out_ready = 1'b1;
    drive(1'b1, 2'b10, 32'h10); step();
    check("stream_alu0", 64'(oa.alu), 64'h10);
    check("stream_valid0", 64'(oa.valid), 64'd1);
    drive(1'b1, 2'b10, 32'h20); step();
    check("stream_alu1", 64'(oa.alu), 64'h20);
    drive(1'b1, 2'b10, 32'h30); step();
    check("stream_alu2", 64'(oa.alu), 64'h30);
    check("stream_ready", 64'(ia.ready), 64'd1);
    drive(1'b0, 2'b00, 32'h0); step();
    check("stream_drain", 64'(oa.valid), 64'd0);

    // Backpressure into the skid entry.
    drive(1'b1, 2'b01, 32'h11); step();
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 32'h22); step();
    check("bp_in_ready", 64'(ia.ready), 64'd0);
    check("bp_hold_alu", 64'(oa.alu), 64'h11);
    check("bp_stall1", 64'(stall_a), 64'd1);
    drive(1'b0, 2'b00, 32'h0); step();
    check("bp_stall2", 64'(stall_a), 64'd2);
    out_ready = 1'b1; step();
    check("bp_second", 64'(oa.alu), 64'h22);
    check("bp_ready_back", 64'(ia.ready), 64'd1);
    step();
    check("bp_empty", 64'(oa.valid), 64'd0);

    // Flush with both entries full and a valid input presented.
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 32'h41); step();
    drive(1'b1, 2'b11, 32'h42); step();
    check("fl_full_ready", 64'(ia.ready), 64'd0);
    check("fl_main_ctrl", 64'(oa.ctrl), 64'd1);
    flush = 1'b1;
    drive(1'b1, 2'b10, 32'h43); step();
    check("fl_valid", 64'(oa.valid), 64'd0);
    check("fl_ctrl", 64'(oa.ctrl), 64'd0);
    check("fl_skid_empty", 64'(ia.ready), 64'd1);
    check("fl_stall_kept", 64'(stall_a), 64'd4);
    flush = 1'b0;
    drive(1'b0, 2'b00, 32'h0); step();
    check("fl_not_captured", 64'(oa.valid), 64'd0);

    // Saturation of the 4-bit counter.
    drive(1'b1, 2'b00, 32'h55); step();
    drive(1'b0, 2'b00, 32'h0);
    for (int i = 0; i < 20; i++) step();
    check("sat_stall", 64'(stall_a), 64'd15);
    check("sat_hold_alu", 64'(oa.alu), 64'h55);

    // Asynchronous reset with both entries full.
    drive(1'b1, 2'b11, 32'h66); step();
    check("rr_full", 64'(ia.ready), 64'd0);
    drive(1'b0, 2'b00, 32'h0);
    rst = 1'b1;
    #1;
    check("rr_valid", 64'(oa.valid), 64'd0);
    check("rr_ctrl", 64'(oa.ctrl), 64'd0);
    check("rr_alu", 64'(oa.alu), 64'd0);
    check("rr_stall", 64'(stall_a), 64'd0);
    check("rr_in_ready", 64'(ia.ready), 64'd1);
    step(); step();
    rst = 1'b0;

    // Single-entry stage: combinational ready and one-cycle replace.
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 32'h77); step();
    check("ns_alu", 64'(ob.alu), 64'h77);
    check("ns_ready_low", 64'(ib.ready), 64'd0);
    out_ready = 1'b1;
    #1;
    check("ns_ready_comb", 64'(ib.ready), 64'd1);
    drive(1'b1, 2'b10, 32'h88); step();
    check("ns_replace_alu", 64'(ob.alu), 64'h88);
    check("ns_replace_valid", 64'(ob.valid), 64'd1);
    drive(1'b0, 2'b00, 32'h0); step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
